// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath register stages: state encoding
// and the default data width.
package mac_pkg;

    localparam int BIT_DEPTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Number of words held in each state.
    function automatic logic [1:0] state_count(input skid_state_e st);
        logic [1:0] cnt;
        case (st)
            ST_EMPTY: cnt = 2'd0;
            ST_BUSY:  cnt = 2'd1;
            ST_FULL:  cnt = 2'd2;
            default:  cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/skid_reg.sv
// Valid/ready pipeline register with one skid entry. in_ready, out_valid,
// out_data and count are all driven straight from flops.
module skid_reg
    import mac_pkg::*;
#(
    parameter int bit_depth = BIT_DEPTH_DEFAULT
) (
    input  logic                 clk_n,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_depth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bit_depth-1:0] out_data,
    output logic [1:0]           count
);

    skid_state_e          state_r;
    skid_state_e          state_nxt_s;
    logic [bit_depth-1:0] main_r;
    logic [bit_depth-1:0] skid_r;
    logic [bit_depth-1:0] main_nxt_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [1:0]           count_r;
    logic                 acc_s;
    logic                 dq_s;
    logic                 main_ld_s;
    logic                 main_from_skid_s;
    logic                 skid_ld_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign count     = count_r;

    // Next-state and data-load decode; flush overrides every handshake.
    always_comb begin
        acc_s            = in_valid & in_ready_r;
        dq_s             = out_valid_r & out_ready;
        state_nxt_s      = state_r;
        main_ld_s        = 1'b0;
        main_from_skid_s = 1'b0;
        skid_ld_s        = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_nxt_s = ST_BUSY;
                        main_ld_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (acc_s && dq_s) begin
                        state_nxt_s = ST_BUSY;
                        main_ld_s   = 1'b1;
                    end else if (acc_s) begin
                        state_nxt_s = ST_FULL;
                        skid_ld_s   = 1'b1;
                    end else if (dq_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // Upstream is blocked here, so only a dequeue can move us.
                    if (dq_s) begin
                        state_nxt_s      = ST_BUSY;
                        main_ld_s        = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
        main_nxt_s = main_from_skid_s ? skid_r : in_data;
    end

    // State plus the handshake/count outputs, decoded from the next state.
    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            count_r     <= state_count(state_nxt_s);
        end
    end

    // Data registers; they keep their contents across dequeue and flush.
    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            main_r <= '0;
            skid_r <= '0;
        end else begin
            if (main_ld_s) begin
                main_r <= main_nxt_s;
            end
            if (skid_ld_s) begin
                skid_r <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomised self-checking bench for skid_reg.
module tb_skid_reg;

    logic        clk_n;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    skid_reg #(.bit_depth(32)) dut (
        .clk_n    (clk_n),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    initial clk_n = 1'b0;
    always #5 clk_n = ~clk_n;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_n);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] c, input logic [31:0] d);
        check_eq({tag, ".count"}, {30'd0, count}, {30'd0, c});
        check_eq({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (c != 2'd0)});
        check_eq({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (c != 2'd2)});
        check_eq({tag, ".out_data"}, out_data, d);
    endtask

    logic [31:0] q[$];
    logic        acc;
    logic        dq;
    logic        stalled;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        #1;
        check_ctl("reset", 2'd0, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Streaming: 1..16 back-to-back with downstream always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
            check_ctl($sformatf("stream%0d", i), 2'd1, i);
        end
        in_valid = 1'b0;
        step();
        check_ctl("stream_drain", 2'd0, 32'd16);

        // Stall fill, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA0001;
        step();
        check_ctl("stall1", 2'd1, 32'hAAAA0001);
        in_data = 32'hAAAA0002;
        step();
        check_ctl("stall2", 2'd2, 32'hAAAA0001);
        in_data = 32'hAAAA0003;
        step();
        check_ctl("stall3_held", 2'd2, 32'hAAAA0001);
        out_ready = 1'b1;
        step();
        check_ctl("release1", 2'd1, 32'hAAAA0002);
        step();
        check_ctl("release2", 2'd1, 32'hAAAA0003);
        in_valid = 1'b0;
        step();
        check_ctl("release3", 2'd0, 32'hAAAA0003);

        // Simultaneous accept and dequeue in BUSY.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11111111;
        step();
        check_ctl("sim_load", 2'd1, 32'h11111111);
        in_data   = 32'h22222222;
        out_ready = 1'b1;
        step();
        check_ctl("sim_swap", 2'd1, 32'h22222222);
        in_valid = 1'b0;
        step();
        check_ctl("sim_drain", 2'd0, 32'h22222222);

        // Flush while FULL with a word offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h33333333;
        step();
        in_data = 32'h44444444;
        step();
        check_ctl("flush_pre", 2'd2, 32'h33333333);
        in_data = 32'h55555555;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_ctl("flush_full", 2'd0, 32'h33333333);

        // Flush in BUSY discards a coincident accept and dequeue.
        in_valid = 1'b1;
        in_data  = 32'h66666666;
        step();
        check_ctl("flush_busy_pre", 2'd1, 32'h66666666);
        in_data   = 32'h77777777;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_ctl("flush_busy", 2'd0, 32'h66666666);
        step();
        check_ctl("flush_idle", 2'd0, 32'h66666666);

        // Asynchronous reset mid-cycle while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h88888888;
        step();
        in_data = 32'h99999999;
        step();
        in_valid = 1'b0;
        check_ctl("rst_pre", 2'd2, 32'h88888888);
        #2;
        rst = 1'b1;
        #1;
        check_ctl("rst_async", 2'd0, 32'd0);
        #1;
        rst = 1'b0;
        step();
        check_ctl("rst_after", 2'd0, 32'd0);

        // Random traffic against a queue scoreboard.
        q.delete();
        stalled = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #3;
            acc = in_valid & in_ready;
            dq  = out_valid & out_ready;
            if (dq) begin
                if (q.size() > 0) begin
                    check_eq("rand.data", out_data, q[0]);
                end else begin
                    check_eq("rand.spurious_dq", 32'd1, 32'd0);
                end
            end
            stalled = in_valid & ~acc;
            @(posedge clk_n);
            #1;
            if (dq && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(in_data);
            end
            check_eq("rand.count", {30'd0, count}, q.size());
            check_eq("rand.out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/skid_reg.md
Name: skid_reg

Overview:
- Handshaked pipeline register stage for the MAC datapath, with a valid/ready interface on both sides.
- Captures a word from an upstream producer and presents it to a downstream consumer.
- A second (skid) entry absorbs one word when downstream stalls, so `in_ready` can be a registered output.
- Sustains one word per cycle with no bubbles and no combinational ready path from `out_ready` to `in_ready`.

Parameters:
- `bit_depth`, 32, width of the data word carried through the stage.

Ports:
- `clk_n` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous clear of both entries. Priority below `rst` and above all handshakes.
- `in_valid` input 1: upstream word available.
- `in_ready` output 1: stage can accept a word; registered.
- `in_data` input `bit_depth`: upstream word.
- `out_valid` output 1: `out_data` holds a valid word; registered.
- `out_ready` input 1: downstream accepts `out_data` this cycle.
- `out_data` output `bit_depth`: head word; registered.
- `count` output 2: entries held (0, 1 or 2); registered.

Behaviour:
- Reset (asserted asynchronously, released synchronously by the environment):
  - `out_valid=0`, `in_ready=1`, `out_data=0`, `count=0`.
  - Skid data register cleared to 0; state EMPTY.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. Data must be held stable while valid=1 and ready=0 on both sides.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid=1` after edge N (one cycle) when the stage was EMPTY.
- States and transitions (acc = `in_valid & in_ready`, dq = `out_valid & out_ready`):
  - EMPTY (`count=0`, `in_ready=1`, `out_valid=0`):
    - acc -> BUSY, main=`in_data`.
  - BUSY (`count=1`, `in_ready=1`, `out_valid=1`):
    - acc & dq -> BUSY, main=`in_data`.
    - acc & !dq -> FULL, skid=`in_data`.
    - !acc & dq -> EMPTY.
    - else hold.
  - FULL (`count=2`, `in_ready=0`, `out_valid=1`):
    - dq -> BUSY, main=skid.
    - else hold. Upstream is blocked, so acc cannot occur.
- Ordering: strict FIFO; the skid word is never presented before the older main word.
- Data registers update only on the listed transitions. `out_data` holds its last value when `out_valid=0`; it is not cleared on dequeue.
- `flush`:
  - Next state EMPTY, `count=0`, `out_valid=0`, `in_ready=1`.
  - Any handshake coinciding with `flush` is discarded, both accept and dequeue.
  - Data registers keep their values.
- `rst` mid-operation: immediate clear to the reset values regardless of the clock. Stored words are lost.
- `in_valid` asserted while `in_ready=0` is ignored; no state change.
- No width arithmetic; data passes bit-exact.
- `count` always equals the number of valid entries. 3 is illegal and must never appear.

Decomposition:
- Shared package `mac_pkg`:
  - State encoding constants `ST_EMPTY=2'd0`, `ST_BUSY=2'd1`, `ST_FULL=2'd2`.
  - Default `bit_depth` constant (32), shared with the existing register stage.
- Sub-module: none required.
- Main and skid data registers may each be built from the team's existing plain reset register with a local load enable wrapper. A single flat module is preferred.

Test Plan:
- Reset:
  - Stimulus: drive `rst=1` asynchronously mid-cycle with `count=2`.
  - Required: `out_valid=0`, `in_ready=1`, `count=0`, `out_data=0` before the next edge.
- Streaming:
  - Stimulus: `out_ready=1` held; send 0x00000001..0x00000010 back-to-back.
  - Required: `out_data` shows 1..16 on consecutive cycles, each one cycle after acceptance; `in_ready` never drops.
- Stall fill:
  - Stimulus: `out_ready=0`; send 0xAAAA0001, 0xAAAA0002, 0xAAAA0003.
  - Required: first two accepted, `count=2`, `in_ready=0`; third held upstream.
  - Then release `out_ready=1`: outputs 0001, 0002, 0003 in order.
- Simultaneous:
  - Stimulus: in BUSY holding 0x11111111, assert accept of 0x22222222 and dequeue on the same edge.
  - Required: `count` stays 1 and `out_data`=0x22222222 next cycle.
- Flush:
  - Stimulus: `count=2` with `in_valid=1`; pulse `flush` for one cycle.
  - Required: `count=0`, `out_valid=0`, `in_ready=1` next cycle; the offered word is not captured.
- Random:
  - Stimulus: 10k cycles of random `in_valid`/`out_ready` against a scoreboard.
  - Required: no loss, duplication or reordering; `count`≤2 always.
